// File: rtl/es_div_ctrl.sv
// EXE-stage iterative divider sequencer: radix-2 restoring DIV/DIVU with stall, flush abort and HI/LO strobe.
// Optional DIV_EARLY_OUT_EN: divide-by-zero or |src1|<|src2| skips the iteration loop and finishes one cycle after the request.
module es_div_ctrl #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          div_req,
  input  logic          div_signed,
  input  logic [DW-1:0] div_src1,
  input  logic [DW-1:0] div_src2,
  input  logic          es_go,
  input  logic          flush,
  output logic          div_busy,
  output logic          div_ready_go,
  output logic [DW-1:0] div_q,
  output logic [DW-1:0] div_r,
  output logic          hilo_we
);

  localparam int unsigned CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW-1:0] quo;
  logic [DW-1:0] dvs;
  logic          q_neg;
  logic          r_neg;

  // Operand conditioning for a request presented in IDLE
  logic [DW-1:0] abs1_c;
  logic [DW-1:0] abs2_c;
  logic          in_qneg_c;
  logic          in_rneg_c;
  logic          early_c;
  logic [DW-1:0] quo_early_c;

  assign abs1_c    = (div_signed && div_src1[DW-1]) ? DW'(0) - div_src1 : div_src1;
  assign abs2_c    = (div_signed && div_src2[DW-1]) ? DW'(0) - div_src2 : div_src2;
  assign in_qneg_c = div_signed & (div_src1[DW-1] ^ div_src2[DW-1]);
  assign in_rneg_c = div_signed & div_src1[DW-1];
  assign quo_early_c = (abs2_c == '0) ? '1 : '0;

`ifdef DIV_EARLY_OUT_EN
  assign early_c = (abs2_c == '0) || (abs1_c < abs2_c);
`else
  assign early_c = 1'b0;
`endif

  // One restoring step; the compare/subtract keeps the shifted-out bit
  logic [DW:0]   shl_c;
  logic [DW-1:0] dif_c;
  logic          ge_c;
  logic [DW-1:0] rem_step_c;
  logic [DW-1:0] quo_step_c;

  assign shl_c      = {rem, quo[DW-1]};
  assign ge_c       = shl_c >= {1'b0, dvs};
  assign dif_c      = DW'(shl_c - {1'b0, dvs});
  assign rem_step_c = ge_c ? dif_c : shl_c[DW-1:0];
  assign quo_step_c = {quo[DW-2:0], ge_c};

  // Magnitudes and signs that become the result on DONE entry
  logic [DW-1:0] fin_q_c;
  logic [DW-1:0] fin_r_c;
  logic          fin_qn_c;
  logic          fin_rn_c;

  assign fin_q_c  = (state == IDLE) ? quo_early_c : quo_step_c;
  assign fin_r_c  = (state == IDLE) ? abs1_c      : rem_step_c;
  assign fin_qn_c = (state == IDLE) ? in_qneg_c   : q_neg;
  assign fin_rn_c = (state == IDLE) ? in_rneg_c   : r_neg;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // hilo_we must land in the same cycle the instruction leaves EXE
  always_comb begin
    state_nxt = state;
    hilo_we   = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && div_req) state_nxt = early_c ? DONE : CALC;
      end
      CALC: begin
        if (flush)                      state_nxt = IDLE;
        else if (cnt == CW'(DW - 1))    state_nxt = DONE;
      end
      DONE: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (es_go) begin
          state_nxt = IDLE;
          hilo_we   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) hilo_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_q        <= '0;
      div_r        <= '0;
      div_busy     <= 1'b0;
      div_ready_go <= 1'b0;
    end else begin
      div_busy     <= (state_nxt != IDLE);
      div_ready_go <= (state_nxt == DONE);
      if (state == IDLE && state_nxt != IDLE) begin
        cnt   <= '0;
        rem   <= '0;
        quo   <= abs1_c;
        dvs   <= abs2_c;
        q_neg <= in_qneg_c;
        r_neg <= in_rneg_c;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        rem <= rem_step_c;
        quo <= quo_step_c;
      end
      if (state != DONE && state_nxt == DONE) begin
        div_q <= fin_qn_c ? DW'(0) - fin_q_c : fin_q_c;
        div_r <= fin_rn_c ? DW'(0) - fin_r_c : fin_r_c;
      end
    end
  end

endmodule

// File: tb/tb_es_div_ctrl.sv
// Randomised plus directed bench for es_div_ctrl against an arithmetic divide model.
module tb_es_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        es_go;
  logic        flush;
  logic        div_busy;
  logic        div_ready_go;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        hilo_we;

  es_div_ctrl #(.DW(32)) dut (
    .clk(clk), .reset(reset), .div_req(div_req), .div_signed(div_signed),
    .div_src1(div_src1), .div_src2(div_src2), .es_go(es_go), .flush(flush),
    .div_busy(div_busy), .div_ready_go(div_ready_go), .div_q(div_q),
    .div_r(div_r), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expectations for the current cycle, written by the driver
  logic        e_busy, e_ready, e_we, e_lit, chk_en;
  logic [31:0] e_q, e_r, e_lq, e_lr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("div_busy", 32'(div_busy), 32'(e_busy));
      chk("div_ready_go", 32'(div_ready_go), 32'(e_ready));
      chk("hilo_we", 32'(hilo_we), 32'(e_we));
      chk("div_q", div_q, e_q);
      chk("div_r", div_r, e_r);
      if (e_lit && e_ready) begin
        chk("div_q_literal", div_q, e_lq);
        chk("div_r_literal", div_r, e_lr);
      end
    end
  end

  // Architectural result: magnitude divide, then sign fix; /0 gives all-ones quotient
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sg,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    logic [31:0] ua, ub, uq, ur;
    bit qn, rn;
    qn = sg && (a[31] != b[31]);
    rn = sg && a[31];
    ua = (sg && a[31]) ? 32'd0 - a : a;
    ub = (sg && b[31]) ? 32'd0 - b : b;
    if (ub == 32'd0) begin uq = 32'hFFFF_FFFF; ur = ua; end
    else begin uq = ua / ub; ur = ua % ub; end
    q = qn ? 32'd0 - uq : uq;
    r = rn ? 32'd0 - ur : ur;
`ifdef DIV_EARLY_OUT_EN
    lat = (ub == 32'd0 || ua < ub) ? 1 : 33;
`else
    lat = 33;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic rd, input logic we);
    e_busy = b; e_ready = rd; e_we = we;
  endtask

  task automatic scramble();
    div_req    = 1'($urandom_range(0, 1));
    div_signed = 1'($urandom_range(0, 1));
    div_src1   = $urandom;
    div_src2   = $urandom;
  endtask

  // One divide: flush_at>0 aborts in that CALC cycle; hold = DONE cycles before es_go
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sg,
                        input int hold, input int flush_at, input bit flush_go,
                        input bit lit, input logic [31:0] lq, input logic [31:0] lr);
    logic [31:0] mq, mr;
    int lat;
    model(a, b, sg, mq, mr, lat);
    div_req = 1'b1; div_signed = sg; div_src1 = a; div_src2 = b;
    es_go = 1'b0; flush = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    for (int c = 1; c < lat; c++) begin
      scramble();
      es_go = 1'($urandom_range(0, 1));
      flush = (c == flush_at);
      set_exp(1'b1, 1'b0, 1'b0);
      step();
      if (c == flush_at) begin
        flush = 1'b0; div_req = 1'b0; es_go = 1'b0;
        return;
      end
    end
    e_q = mq; e_r = mr;
    e_lit = lit; e_lq = lq; e_lr = lr;
    for (int h = 0; h <= hold; h++) begin
      scramble();
      es_go = (h == hold);
      flush = (h == hold) && flush_go;
      set_exp(1'b1, 1'b1, (h == hold) && !flush_go);
      step();
    end
    e_lit = 1'b0;
    div_req = 1'b0; es_go = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'($urandom_range(1, 20));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; div_req = 1'b0; div_signed = 1'b0; div_src1 = '0; div_src2 = '0;
    es_go = 1'b0; flush = 1'b0; e_lit = 1'b0; e_lq = '0; e_lr = '0;
    e_q = '0; e_r = '0; set_exp(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    run_op(32'd100, 32'd7, 1'b0, 0, 0, 1'b0, 1'b1, 32'd14, 32'd2);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1, 0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0, 1'b1, 32'h8000_0000, 32'd0);
    run_op(32'd5, 32'd0, 1'b0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5);
    run_op(32'd3, 32'd9, 1'b0, 0, 0, 1'b0, 1'b1, 32'd0, 32'd3);
    // Abort mid-loop, then a clean divide right behind it
    run_op(32'd1000, 32'd9, 1'b0, 0, 10, 1'b0, 1'b0, '0, '0);
    run_op(32'd1000, 32'd9, 1'b0, 0, 0, 1'b0, 1'b1, 32'd111, 32'd1);
    // Long stall in DONE ending with es_go and flush together
    run_op(32'd77, 32'd5, 1'b0, 5, 0, 1'b1, 1'b1, 32'd15, 32'd2);
    // Request coinciding with flush in IDLE is not accepted
    div_req = 1'b1; div_src1 = 32'd50; div_src2 = 32'd3; flush = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    div_req = 1'b0; flush = 1'b0;
    step();

    for (int n = 0; n < 45; n++) begin
      run_op(rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 32)) : 0,
             $urandom_range(0, 6) == 0, 1'b0, '0, '0);
      if ($urandom_range(0, 2) == 0) begin
        set_exp(1'b0, 1'b0, 1'b0);
        step();
      end
    end

    // Synchronous reset in the middle of the loop
    div_req = 1'b1; div_signed = 1'b0; div_src1 = 32'd1000; div_src2 = 32'd3;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    for (int c = 1; c <= 10; c++) begin
      div_req = 1'b0; es_go = 1'b1;
      reset = (c == 10);
      set_exp(1'b1, 1'b0, 1'b0);
      step();
    end
    reset = 1'b0; es_go = 1'b0;
    e_q = '0; e_r = '0;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    run_op(32'd1000, 32'd3, 1'b0, 0, 0, 1'b0, 1'b1, 32'd333, 32'd1);
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
